// File: rtl/program_counter_stack_if.sv
// Fetch-stage control/address bundle for program_counter_stack.
// The master side drives op/addr_in/stall/debug-run; the slave side returns the PC and stack status.
interface program_counter_stack_if #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned STACK_DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

   logic                  enableDebug;
   logic                  notEnable;
   logic [2:0]            op;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [CNT_W-1:0]      stack_count;
   logic                  stack_overflow;
   logic                  stack_underflow;

   modport master (
      output enableDebug, notEnable, op, addr_in,
      input  addr_out, addr_inc, stack_count, stack_overflow, stack_underflow
   );

   modport slave (
      input  enableDebug, notEnable, op, addr_in,
      output addr_out, addr_inc, stack_count, stack_overflow, stack_underflow
   );
endinterface

// File: rtl/program_counter_stack.sv
// Registered program counter with relative/absolute control flow and a
// hardware return-address stack (CALL/RET) reporting overflow/underflow pulses.
module program_counter_stack #(
   parameter int unsigned            ADDR_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR  = '0,
   parameter int unsigned            STACK_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      resetDebug,
   program_counter_stack_if.slave    bus
);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_INC    = 3'b000;
   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_CALL   = 3'b011;
   localparam logic [2:0] OP_RET    = 3'b100;

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_next;
   logic                  ovf;
   logic                  unf;
   logic                  ovf_next;
   logic                  unf_next;
   logic                  any_reset;
   logic                  adv;
   logic                  full;
   logic                  empty;
   logic                  push_en;
   logic [PTR_W-1:0]      push_idx;
   logic [PTR_W-1:0]      top_idx;
   logic [ADDR_WIDTH-1:0] top_entry;

   logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

   assign any_reset = ~reset | resetDebug;
   assign adv       = bus.enableDebug & ~bus.notEnable;
   assign pc_inc    = pc + ADDR_WIDTH'(1);
   assign full      = (count == CNT_W'(STACK_DEPTH));
   assign empty     = (count == '0);
   assign push_idx  = PTR_W'(count);
   assign top_idx   = PTR_W'(count - CNT_W'(1));
   assign top_entry = stack_mem[top_idx];

   // Same-width add: two's-complement offset wraps exactly like sign extension.
   always_comb begin
      pc_next    = pc;
      count_next = count;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
      push_en    = 1'b0;
      if (adv) begin
         case (bus.op)
            OP_BRANCH: pc_next = pc + bus.addr_in;
            OP_JUMP:   pc_next = bus.addr_in;
            OP_CALL: begin
               pc_next = bus.addr_in;
               if (full) begin
                  ovf_next = 1'b1;
               end else begin
                  push_en    = 1'b1;
                  count_next = count + CNT_W'(1);
               end
            end
            OP_RET: begin
               if (empty) begin
                  pc_next  = pc_inc;
                  unf_next = 1'b1;
               end else begin
                  pc_next    = top_entry;
                  count_next = count - CNT_W'(1);
               end
            end
            default:   pc_next = pc_inc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (any_reset) begin
         pc    <= RESET_ADDR;
         count <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         pc    <= pc_next;
         count <= count_next;
         ovf   <= ovf_next;
         unf   <= unf_next;
      end
   end

   // Stack storage needs no reset; a reset cycle suppresses the push instead.
   always_ff @(posedge clk) begin
      if (push_en && !any_reset) begin
         stack_mem[push_idx] <= pc_inc;
      end
   end

   assign bus.addr_out        = pc;
   assign bus.addr_inc        = pc_inc;
   assign bus.stack_count     = count;
   assign bus.stack_overflow  = ovf;
   assign bus.stack_underflow = unf;
endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_program_counter_stack;
   localparam int unsigned         AW    = 8;
   localparam int unsigned         DEPTH = 4;
   localparam logic [AW-1:0]       RADDR = 8'h10;

   localparam logic [2:0] INC = 3'b000, BRANCH = 3'b001, JUMP = 3'b010,
                          CALL = 3'b011, RET = 3'b100;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic resetDebug = 1'b0;

   program_counter_stack_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH)) bus ();

   program_counter_stack #(.ADDR_WIDTH(AW), .RESET_ADDR(RADDR), .STACK_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .resetDebug (resetDebug),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model
   int              m_pc;
   int              m_stack[$];
   bit              m_ovf, m_unf;
   bit              m_valid = 1'b0;

   always @(posedge clk) begin
      if (!reset || resetDebug) begin
         m_pc = RADDR;
         m_stack.delete();
         m_ovf = 0;
         m_unf = 0;
         m_valid = 1'b1;
      end else if (!(bus.enableDebug && !bus.notEnable)) begin
         m_ovf = 0;
         m_unf = 0;
      end else begin
         m_ovf = 0;
         m_unf = 0;
         case (bus.op)
            BRANCH: m_pc = (m_pc + int'(bus.addr_in)) % 256;
            JUMP:   m_pc = int'(bus.addr_in);
            CALL: begin
               if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
               else m_ovf = 1;
               m_pc = int'(bus.addr_in);
            end
            RET: begin
               if (m_stack.size() > 0) m_pc = m_stack.pop_back();
               else begin
                  m_pc = (m_pc + 1) % 256;
                  m_unf = 1;
               end
            end
            default: m_pc = (m_pc + 1) % 256;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_addr_out", 32'(bus.addr_out), 32'(m_pc));
         chk("m_addr_inc", 32'(bus.addr_inc), 32'((m_pc + 1) % 256));
         chk("m_count", 32'(bus.stack_count), 32'(m_stack.size()));
         chk("m_overflow", 32'(bus.stack_overflow), 32'(m_ovf));
         chk("m_underflow", 32'(bus.stack_underflow), 32'(m_unf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [AW-1:0] a);
      bus.op = o;
      bus.addr_in = a;
      tick();
   endtask

   logic [AW-1:0] call_tgt [5];
   logic [AW-1:0] ret_exp  [4];

   initial begin
      bus.enableDebug = 1'b1;
      bus.notEnable   = 1'b0;
      bus.op          = INC;
      bus.addr_in     = '0;
      call_tgt = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
      ret_exp  = '{8'hB1, 8'hA1, 8'h91, 8'h81};

      // Reset then INC
      tick(); tick();
      chk("reset_pc", 32'(bus.addr_out), 32'h10);
      chk("reset_cnt", 32'(bus.stack_count), 32'h0);
      reset = 1'b1;
      drive(INC, '0); chk("inc1", 32'(bus.addr_out), 32'h11);
      drive(INC, '0); chk("inc2", 32'(bus.addr_out), 32'h12);
      drive(INC, '0); chk("inc3", 32'(bus.addr_out), 32'h13);
      chk("inc3_addr_inc", 32'(bus.addr_inc), 32'h14);

      // Stall and debug freeze
      drive(JUMP, 8'h05);
      bus.notEnable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(INC, '0);
         chk("stall_hold", 32'(bus.addr_out), 32'h05);
      end
      bus.notEnable = 1'b0;
      bus.enableDebug = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(CALL, 8'h77);
         chk("freeze_hold", 32'(bus.addr_out), 32'h05);
         chk("freeze_cnt", 32'(bus.stack_count), 32'h0);
      end
      bus.enableDebug = 1'b1;
      drive(INC, '0); chk("resume", 32'(bus.addr_out), 32'h06);

      // Branch backwards and wrap
      drive(JUMP, 8'h02);
      drive(BRANCH, 8'hFC); chk("branch_neg", 32'(bus.addr_out), 32'hFE);
      drive(JUMP, 8'hFF);
      drive(INC, '0); chk("inc_wrap", 32'(bus.addr_out), 32'h00);
      drive(BRANCH, 8'hFF); chk("branch_wrap", 32'(bus.addr_out), 32'hFF);
      drive(CALL, 8'h40);
      drive(RET, '0); chk("call_at_max", 32'(bus.addr_out), 32'h00);
      drive(op_unused(), '0); chk("op_7_inc", 32'(bus.addr_out), 32'h01);

      // Nested call/return, back-to-back CALL->RET
      drive(JUMP, 8'h20);
      drive(CALL, 8'h40); chk("nest_pc1", 32'(bus.addr_out), 32'h40); chk("nest_c1", 32'(bus.stack_count), 1);
      drive(CALL, 8'h60); chk("nest_pc2", 32'(bus.addr_out), 32'h60); chk("nest_c2", 32'(bus.stack_count), 2);
      drive(RET, '0);     chk("nest_pc3", 32'(bus.addr_out), 32'h41); chk("nest_c3", 32'(bus.stack_count), 1);
      drive(RET, '0);     chk("nest_pc4", 32'(bus.addr_out), 32'h21); chk("nest_c4", 32'(bus.stack_count), 0);

      // Overflow then underflow
      drive(JUMP, 8'h80);
      for (int i = 0; i < 5; i++) begin
         drive(CALL, call_tgt[i]);
         chk("ovf_flag", 32'(bus.stack_overflow), (i == 4) ? 1 : 0);
      end
      chk("ovf_cnt", 32'(bus.stack_count), 4);
      chk("ovf_pc", 32'(bus.addr_out), 32'hD0);
      for (int i = 0; i < 4; i++) begin
         drive(RET, '0);
         chk("ret_order", 32'(bus.addr_out), 32'(ret_exp[i]));
         chk("ovf_clear", 32'(bus.stack_overflow), 0);
      end
      drive(RET, '0);
      chk("unf_flag", 32'(bus.stack_underflow), 1);
      chk("unf_pc", 32'(bus.addr_out), 32'h82);
      drive(INC, '0);
      chk("unf_clear", 32'(bus.stack_underflow), 0);

      // Reset priority
      drive(JUMP, 8'h30);
      drive(CALL, 8'h50);
      reset = 1'b0;
      drive(CALL, 8'h70);
      chk("rst_call_pc", 32'(bus.addr_out), 32'h10);
      chk("rst_call_cnt", 32'(bus.stack_count), 0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) drive(CALL, 8'h50);
      reset = 1'b0;
      drive(CALL, 8'h60);
      chk("rst_full_ovf", 32'(bus.stack_overflow), 0);
      reset = 1'b1;
      drive(CALL, 8'h50);
      bus.notEnable = 1'b1;
      resetDebug = 1'b1;
      drive(CALL, 8'h60);
      chk("dbg_rst_pc", 32'(bus.addr_out), 32'h10);
      chk("dbg_rst_cnt", 32'(bus.stack_count), 0);
      chk("dbg_rst_ovf", 32'(bus.stack_overflow), 0);
      resetDebug = 1'b0;
      bus.notEnable = 1'b0;
      drive(RET, '0);
      chk("post_rst_unf", 32'(bus.stack_underflow), 1);
      chk("post_rst_pc", 32'(bus.addr_out), 32'h11);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   function automatic logic [2:0] op_unused();
      return 3'b111;
   endfunction
endmodule
